legv8_control_unit: RTL and testbench

Multi-cycle control unit for the LEGv8 datapath test system. Decodes the 32-bit instruction register and the status flags, then drives the 40-bit ControlWord and 64-bit constant that the datapath consumes every cycle. A 3-bit state register closes the loop: it loads the NS field of the ControlWord it emitted on each clock edge.

---
 rtl/legv8_control_unit.sv | 271 +++++++++++++++++++++++++++
 tb/tb_legv8_control_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_unit.sv
// legv8_control_unit
//
// Multi-cycle control unit for the LEGv8 datapath. It decodes the instruction register and the
// stored/live flags into the 40-bit ControlWord and the 64-bit constant, both of which are
// combinational. The 3-bit state register loads the NS field of the word it emits on every clock
// edge.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high; forces FETCH
//   IR             instruction register contents
//   status         {V,C,N,Z stored flags, ALU-data-enable}
//   current_status live ALU flags {V,C,N,Z}
//   ControlWord    {CGS, NS, AS, DS, PS, PCsel, Bsel, IL, SL, FS, C0, size, MW, RW, DA, SA, SB}
//   constant       immediate selected by CGS
//   state          current state (debug)
//   halted         high while in HALT

module legv8_control_unit #(
    parameter logic [4:0] LINK_REG   = 5'd30,
    parameter logic [1:0] FETCH_SIZE = 2'b10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [4:0]  status,
    input  logic [3:0]  current_status,
    output logic [39:0] ControlWord,
    output logic [63:0] constant,
    output logic [2:0]  state,
    output logic        halted
);

    typedef enum logic [2:0] {
        StFetch = 3'd0,
        StExec  = 3'd1,
        StExec2 = 3'd2,
        StHalt  = 3'd7
    } state_e;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;

    localparam logic [1:0] PS_HOLD  = 2'b00;
    localparam logic [1:0] PS_INC   = 2'b01;
    localparam logic [1:0] PS_CONST = 2'b10;

    localparam logic [1:0] DS_ALU = 2'b00;
    localparam logic [1:0] DS_B   = 2'b01;
    localparam logic [1:0] DS_PC  = 2'b10;
    localparam logic [1:0] DS_MEM = 2'b11;

    localparam logic [2:0] CGS_ZERO = 3'b000;
    localparam logic [2:0] CGS_I12  = 3'b001;
    localparam logic [2:0] CGS_D9   = 3'b010;
    localparam logic [2:0] CGS_B26  = 3'b011;
    localparam logic [2:0] CGS_B19  = 3'b100;

    state_e state_q;
    logic   halted_q;

    // ControlWord fields
    logic [2:0] cgs;
    logic [2:0] ns;
    logic       a_sel;
    logic [1:0] ds;
    logic [1:0] ps;
    logic       pc_sel;
    logic       b_sel;
    logic       il;
    logic       sl;
    logic [4:0] fs;
    logic       c0;
    logic [1:0] size;
    logic       mw;
    logic       rw;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;

    // Only the live Z flag and the stored flags feed decode.
    logic [3:0] unused_bits;
    assign unused_bits = {status[0], current_status[3:1]};

    // cond[3:1] picks the base test, cond[0] inverts it; 111x is always.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic v, c, n, z, base;
        {v, c, n, z} = flags;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cond[3:1] == 3'b111) ? 1'b1 : (base ^ cond[0]);
    endfunction

    always_comb begin
        cgs    = CGS_ZERO;
        ns     = StFetch;
        a_sel  = 1'b0;
        ds     = DS_ALU;
        ps     = PS_HOLD;
        pc_sel = 1'b0;
        b_sel  = 1'b0;
        il     = 1'b0;
        sl     = 1'b0;
        fs     = FS_AND;
        c0     = 1'b0;
        size   = 2'b00;
        mw     = 1'b0;
        rw     = 1'b0;
        da     = 5'd0;
        sa     = 5'd0;
        sb     = 5'd0;

        case (state_q)
            StFetch: begin
                a_sel = 1'b1;
                ds    = DS_MEM;
                size  = FETCH_SIZE;
                il    = 1'b1;
                ps    = PS_INC;
                ns    = StExec;
            end

            StExec: begin
                da = IR[4:0];
                sa = IR[9:5];
                sb = IR[20:16];
                unique casez (IR[31:21])
                    11'b10001011000: begin // ADD
                        fs = FS_ADD;
                        rw = 1'b1;
                    end
                    11'b11001011000: begin // SUB
                        fs = FS_SUB;
                        c0 = 1'b1;
                        rw = 1'b1;
                    end
                    11'b11101011000: begin // SUBS
                        fs = FS_SUB;
                        c0 = 1'b1;
                        sl = 1'b1;
                        rw = 1'b1;
                    end
                    11'b10001010000: begin // AND
                        fs = FS_AND;
                        rw = 1'b1;
                    end
                    11'b10101010000: begin // ORR
                        fs = FS_ORR;
                        rw = 1'b1;
                    end
                    11'b11001010000: begin // EOR
                        fs = FS_EOR;
                        rw = 1'b1;
                    end
                    11'b1001000100?: begin // ADDI
                        fs    = FS_ADD;
                        b_sel = 1'b1;
                        cgs   = CGS_I12;
                        rw    = 1'b1;
                    end
                    11'b1101000100?: begin // SUBI
                        fs    = FS_SUB;
                        c0    = 1'b1;
                        b_sel = 1'b1;
                        cgs   = CGS_I12;
                        rw    = 1'b1;
                    end
                    11'b11111000010: begin // LDUR
                        b_sel = 1'b1;
                        cgs   = CGS_D9;
                        fs    = FS_ADD;
                        ds    = DS_MEM;
                        size  = 2'b11;
                        rw    = 1'b1;
                    end
                    11'b11111000000: begin // STUR: Rt rides the B bus to memory data
                        b_sel = 1'b1;
                        cgs   = CGS_D9;
                        fs    = FS_ADD;
                        sb    = IR[4:0];
                        ds    = DS_B;
                        size  = 2'b11;
                        mw    = 1'b1;
                    end
                    11'b000101?????: begin // B
                        cgs    = CGS_B26;
                        pc_sel = 1'b1;
                        ps     = PS_CONST;
                    end
                    11'b100101?????: begin // BL: link now, branch in EXEC2
                        ds = DS_PC;
                        rw = 1'b1;
                        da = LINK_REG;
                        ns = StExec2;
                    end
                    11'b10110100???, 11'b10110101???: begin // CBZ / CBNZ on live Z
                        sa     = IR[4:0];
                        sb     = 5'd31;
                        fs     = FS_ADD;
                        cgs    = CGS_B19;
                        pc_sel = 1'b1;
                        ps     = (current_status[0] ^ IR[24]) ? PS_CONST : PS_HOLD;
                    end
                    11'b01010100???: begin // B.cond on stored flags
                        cgs    = CGS_B19;
                        pc_sel = 1'b1;
                        ps     = cond_holds(IR[3:0], status[4:1]) ? PS_CONST : PS_HOLD;
                    end
                    default: begin
                        da = 5'd0;
                        sa = 5'd0;
                        sb = 5'd0;
                        ns = StHalt;
                    end
                endcase
            end

            StExec2: begin
                cgs    = CGS_B26;
                pc_sel = 1'b1;
                ps     = PS_CONST;
                ns     = StFetch;
            end

            default: begin
                ns = StHalt;
            end
        endcase
    end

    assign ControlWord = {cgs, ns, a_sel, ds, ps, pc_sel, b_sel, il, sl, fs, c0, size, mw, rw,
                          da, sa, sb};

    // Branch offsets subtract 4 because FETCH already advanced the PC. EXEC2 of BL subtracts a
    // further 4 on top of that.
    always_comb begin
        case (cgs)
            CGS_I12: constant = {52'd0, IR[21:10]};
            CGS_D9:  constant = {{55{IR[20]}}, IR[20:12]};
            CGS_B26: constant = {{36{IR[25]}}, IR[25:0], 2'b00} - 64'd4
                                - ((state_q == StExec2) ? 64'd4 : 64'd0);
            CGS_B19: constant = {{43{IR[23]}}, IR[23:5], 2'b00} - 64'd4;
            default: constant = 64'd0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StFetch;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_e'(ns);
            halted_q <= (ns == StHalt);
        end
    end

    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Bench for legv8_control_unit: a table of EXEC-state decode vectors plus hand sequences for
// reset, BL/EXEC2, HALT and reset during EXEC.

module tb_legv8_control_unit;

    logic        clock;
    logic        reset;
    logic [31:0] IR;
    logic [4:0]  status;
    logic [3:0]  current_status;
    logic [39:0] ControlWord;
    logic [63:0] constant;
    logic [2:0]  state;
    logic        halted;

    legv8_control_unit dut (
        .clock          (clock),
        .reset          (reset),
        .IR             (IR),
        .status         (status),
        .current_status (current_status),
        .ControlWord    (ControlWord),
        .constant       (constant),
        .state          (state),
        .halted         (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [39:0] FETCH_CW = 40'h07_A404_0000;
    localparam logic [39:0] HALT_CW  = 40'h1C_0000_0000;

    localparam logic [4:0] F_AND = 5'b00000;
    localparam logic [4:0] F_ORR = 5'b00100;
    localparam logic [4:0] F_ADD = 5'b01000;
    localparam logic [4:0] F_SUB = 5'b01001;
    localparam logic [4:0] F_EOR = 5'b01100;

    // Don't-care mask bits for fields a vector leaves unconstrained
    localparam logic [9:0] DC_DA = 10'h001;
    localparam logic [9:0] DC_SA = 10'h002;
    localparam logic [9:0] DC_SB = 10'h004;
    localparam logic [9:0] DC_PCS = 10'h008;
    localparam logic [9:0] DC_SZ = 10'h010;
    localparam logic [9:0] DC_FS = 10'h020;
    localparam logic [9:0] DC_BS = 10'h040;
    localparam logic [9:0] DC_DS = 10'h080;
    localparam logic [9:0] DC_AS = 10'h100;
    localparam logic [9:0] DC_K = 10'h200;

    localparam logic [9:0] DC_R  = DC_SZ | DC_PCS | DC_AS | DC_K;
    localparam logic [9:0] DC_I  = DC_SZ | DC_PCS | DC_AS;
    localparam logic [9:0] DC_B  = DC_DA | DC_SA | DC_SB | DC_SZ | DC_FS | DC_BS | DC_DS | DC_AS;
    localparam logic [9:0] DC_BC = DC_B | DC_PCS;
    localparam logic [9:0] DC_CB = DC_DA | DC_SZ | DC_BS | DC_DS | DC_AS | DC_PCS;
    localparam logic [9:0] DC_BL = DC_SA | DC_SB | DC_SZ | DC_FS | DC_BS | DC_AS | DC_PCS | DC_K;
    localparam logic [9:0] DC_ALL = 10'h3FF;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [4:0]  st;
        logic [3:0]  cs;
        logic [2:0]  ns;
        logic        a_sel;
        logic [1:0]  ds;
        logic [1:0]  ps;
        logic        pcs;
        logic        bs;
        logic        sl;
        logic [4:0]  fs;
        logic        c0;
        logic [1:0]  sz;
        logic        mw;
        logic        rw;
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [63:0] k;
        logic [9:0]  dc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string n, input logic [31:0] ir, input logic [4:0] st,
                       input logic [3:0] cs, input logic [2:0] ns, input logic a,
                       input logic [1:0] ds, input logic [1:0] ps, input logic pcs,
                       input logic bs, input logic sl, input logic [4:0] fs, input logic c0,
                       input logic [1:0] sz, input logic mw, input logic rw,
                       input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                       input logic [63:0] k, input logic [9:0] dc);
        vec_t v;
        v = '{name: n, ir: ir, st: st, cs: cs, ns: ns, a_sel: a, ds: ds, ps: ps, pcs: pcs,
              bs: bs, sl: sl, fs: fs, c0: c0, sz: sz, mw: mw, rw: rw, da: da, sa: sa, sb: sb,
              k: k, dc: dc};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reset into FETCH with the instruction already in IR, then step into EXEC.
    task automatic go_exec(input logic [31:0] ir_v, input logic [4:0] st_v,
                           input logic [3:0] cs_v);
        @(negedge clock);
        reset = 1'b1;
        IR = ir_v;
        status = st_v;
        current_status = cs_v;
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic check_vec(input vec_t v);
        logic bad;
        bad = 1'b0;
        if (ControlWord[36:34] !== v.ns) bad = 1'b1;
        if (ControlWord[30:29] !== v.ps) bad = 1'b1;
        if (ControlWord[25] !== v.sl) bad = 1'b1;
        if (ControlWord[16] !== v.mw) bad = 1'b1;
        if (ControlWord[15] !== v.rw) bad = 1'b1;
        if (!v.dc[8] && ControlWord[33] !== v.a_sel) bad = 1'b1;
        if (!v.dc[7] && ControlWord[32:31] !== v.ds) bad = 1'b1;
        if (!v.dc[3] && ControlWord[28] !== v.pcs) bad = 1'b1;
        if (!v.dc[6] && ControlWord[27] !== v.bs) bad = 1'b1;
        if (!v.dc[5] && {ControlWord[24:20], ControlWord[19]} !== {v.fs, v.c0}) bad = 1'b1;
        if (!v.dc[4] && ControlWord[18:17] !== v.sz) bad = 1'b1;
        if (!v.dc[0] && ControlWord[14:10] !== v.da) bad = 1'b1;
        if (!v.dc[1] && ControlWord[9:5] !== v.sa) bad = 1'b1;
        if (!v.dc[2] && ControlWord[4:0] !== v.sb) bad = 1'b1;
        if (!v.dc[9] && constant !== v.k) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got cw=0x%010h k=0x%016h, expected ns=%0d ps=%0d sl=%0d mw=%0d rw=%0d as=%0d ds=%0d pcs=%0d bs=%0d fs=%05b c0=%0d sz=%0d da=%0d sa=%0d sb=%0d k=0x%016h dc=0x%03h",
                     v.name, ControlWord, constant, v.ns, v.ps, v.sl, v.mw, v.rw, v.a_sel,
                     v.ds, v.pcs, v.bs, v.fs, v.c0, v.sz, v.da, v.sa, v.sb, v.k, v.dc);
        end
    endtask

    initial begin
        IR = 32'd0;
        status = 5'd0;
        current_status = 4'd0;
        reset = 1'b1;

        // name, ir, status, cur, ns, as, ds, ps, pcs, bs, sl, fs, c0, sz, mw, rw, da, sa, sb, k, dc
        add("ADD",     32'h8B020020, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_ADD, 0, 2'b00, 0, 1, 5'd0, 5'd1, 5'd2, 64'd0, DC_R);
        add("SUB",     32'hCB0600A4, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_SUB, 1, 2'b00, 0, 1, 5'd4, 5'd5, 5'd6, 64'd0, DC_R);
        add("SUBS",    32'hEB030063, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 1, F_SUB, 1, 2'b00, 0, 1, 5'd3, 5'd3, 5'd3, 64'd0, DC_R);
        add("AND",     32'h8A030041, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 1, 5'd1, 5'd2, 5'd3, 64'd0, DC_R);
        add("ORR",     32'hAA030041, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_ORR, 0, 2'b00, 0, 1, 5'd1, 5'd2, 5'd3, 64'd0, DC_R);
        add("EOR",     32'hCA030041, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_EOR, 0, 2'b00, 0, 1, 5'd1, 5'd2, 5'd3, 64'd0, DC_R);
        add("ADDI",    32'h91048D07, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 1, 0, F_ADD, 0, 2'b00, 0, 1, 5'd7, 5'd8, 5'd4, 64'h123, DC_I);
        add("SUBI",    32'hD1200129, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 1, 0, F_SUB, 1, 2'b00, 0, 1, 5'd9, 5'd9, 5'd0, 64'h800, DC_I);
        add("LDUR",    32'hF85F80C5, 5'b00000, 4'b0000, 3'd0, 0, 2'b11, 2'b00, 0, 1, 0, F_ADD, 0, 2'b11, 0, 1, 5'd5, 5'd6, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, DC_SB | DC_PCS);
        add("STUR",    32'hF80100C5, 5'b00000, 4'b0000, 3'd0, 0, 2'b01, 2'b00, 0, 1, 0, F_ADD, 0, 2'b00, 1, 0, 5'd0, 5'd6, 5'd5, 64'h10, DC_DA | DC_PCS | DC_SZ);
        add("B_fwd",   32'h14000002, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 1, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_B);
        add("B_back",  32'h17FFFFFF, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 1, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, DC_B);
        add("BL_exec", 32'h94000004, 5'b00000, 4'b0000, 3'd2, 0, 2'b10, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 1, 5'd30, 5'd0, 5'd0, 64'd0, DC_BL);
        add("CBZ_t",   32'hB4000063, 5'b00000, 4'b0001, 3'd0, 0, 2'b00, 2'b10, 0, 0, 0, F_ADD, 0, 2'b00, 0, 0, 5'd0, 5'd3, 5'd31, 64'd8, DC_CB);
        add("CBZ_nt",  32'hB4000063, 5'b00010, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_ADD, 0, 2'b00, 0, 0, 5'd0, 5'd3, 5'd31, 64'd8, DC_CB);
        add("CBNZ_t",  32'hB5000063, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 0, 0, 0, F_ADD, 0, 2'b00, 0, 0, 5'd0, 5'd3, 5'd31, 64'd8, DC_CB);
        add("CBNZ_nt", 32'hB5000063, 5'b00000, 4'b0001, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_ADD, 0, 2'b00, 0, 0, 5'd0, 5'd3, 5'd31, 64'd8, DC_CB);
        add("BEQ_t",   32'h54000040, 5'b00011, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BEQ_nt",  32'h54000040, 5'b00000, 4'b0001, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BGE_t",   32'h5400004A, 5'b10100, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BGE_nt",  32'h5400004A, 5'b00100, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BHI_t",   32'h54000048, 5'b01000, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BHI_nt",  32'h54000048, 5'b01010, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BLE_t",   32'h5400004D, 5'b00010, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BLE_nt",  32'h5400004D, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BLO_t",   32'h54000043, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BLO_nt",  32'h54000043, 5'b01000, 4'b0000, 3'd0, 0, 2'b00, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("BAL",     32'h5400004E, 5'b00000, 4'b0000, 3'd0, 0, 2'b00, 2'b10, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd4, DC_BC);
        add("UNDEF_F", 32'hFFFFFFFF, 5'b00000, 4'b0000, 3'd7, 0, 2'b00, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, DC_ALL);
        add("UNDEF_0", 32'h00000000, 5'b00000, 4'b0000, 3'd7, 0, 2'b00, 2'b00, 0, 0, 0, F_AND, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, DC_ALL);

        // Reset state, asynchronous FETCH word
        #12;
        check("reset_state", {61'd0, state}, 64'd0);
        check("reset_halted", {63'd0, halted}, 64'd0);
        check("reset_cw", {24'd0, ControlWord}, {24'd0, FETCH_CW});
        check("reset_const", constant, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("fetch_cw", {24'd0, ControlWord}, {24'd0, FETCH_CW});
        @(posedge clock);
        #1;
        check("fetch_to_exec", {61'd0, state}, 64'd1);

        // Decode table, each followed by a check of the state it loads
        foreach (vecs[i]) begin
            go_exec(vecs[i].ir, vecs[i].st, vecs[i].cs);
            check({vecs[i].name, "_in_exec"}, {61'd0, state}, 64'd1);
            check_vec(vecs[i]);
            @(posedge clock);
            #1;
            check({vecs[i].name, "_next"}, {61'd0, state}, {61'd0, vecs[i].ns});
        end

        // BL: link in EXEC, branch in EXEC2, then back to FETCH
        go_exec(32'h94000004, 5'd0, 4'd0);
        check("bl_exec_ds_da_rw_ns", {48'd0, ControlWord[32:31], ControlWord[14:10],
              ControlWord[15], ControlWord[36:34], 5'd0},
              {48'd0, 2'b10, 5'd30, 1'b1, 3'd2, 5'd0});
        @(posedge clock);
        #1;
        check("bl_exec2_state", {61'd0, state}, 64'd2);
        check("bl_exec2_ps", {62'd0, ControlWord[30:29]}, 64'd2);
        check("bl_exec2_pcsel", {63'd0, ControlWord[28]}, 64'd1);
        check("bl_exec2_const", constant, 64'd8);
        check("bl_exec2_nowrite", {62'd0, ControlWord[16:15]}, 64'd0);
        @(posedge clock);
        #1;
        check("bl_back_fetch", {61'd0, state}, 64'd0);

        // HALT is sticky until reset
        go_exec(32'hFFFFFFFF, 5'd0, 4'd0);
        check("halt_exec_halted", {63'd0, halted}, 64'd0);
        @(posedge clock);
        #1;
        check("halt_state", {61'd0, state}, 64'd7);
        check("halt_halted", {63'd0, halted}, 64'd1);
        check("halt_cw", {24'd0, ControlWord}, {24'd0, HALT_CW});
        check("halt_const", constant, 64'd0);
        IR = 32'h8B020020;
        repeat (10) @(posedge clock);
        #1;
        check("halt_stays", {61'd0, state}, 64'd7);
        check("halt_stays_halted", {63'd0, halted}, 64'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("halt_reset_state", {61'd0, state}, 64'd0);
        check("halt_reset_halted", {63'd0, halted}, 64'd0);

        // Reset asserted mid-EXEC of LDUR drops RW immediately
        go_exec(32'hF85F80C5, 5'd0, 4'd0);
        check("ldur_rw", {63'd0, ControlWord[15]}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ldur_rst_rw", {63'd0, ControlWord[15]}, 64'd0);
        check("ldur_rst_state", {61'd0, state}, 64'd0);
        check("ldur_rst_cw", {24'd0, ControlWord}, {24'd0, FETCH_CW});
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("ldur_refetch", {61'd0, state}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
